// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, valid/ready response.
// Optional DMEM_ADDR_CHECK_EN flags misaligned or out-of-range addresses via rsp_err.
module dmem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          we_q;
   logic [3:0]    wstrb_q;

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx_c;
   logic          err_c;
   logic          access_c;
   logic          commit_c;

   assign idx_c = addr_q[AW+1:2];

`ifdef DMEM_ADDR_CHECK_EN
   assign err_c = (addr_q[1:0] != 2'b00) || (64'(addr_q) >= (64'(DEPTH) * 64'd4));
`else
   // Byte offset and upper bits are don't-care; addresses alias modulo 4*DEPTH.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_q[31:AW+2], addr_q[1:0]};
   assign err_c = 1'b0;
`endif

   assign access_c = (state == WAIT) && (cnt == '0);
   // A reset arriving on the commit edge drops the store.
   assign commit_c = access_c && we_q && !err_c && !rst;

   // Byte-masked store into the word array; contents survive reset.
   always_ff @(posedge clk) begin
      if (commit_c) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
               mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         wstrb_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  we_q      <= req_we;
                  wstrb_q   <= req_wstrb;
                  cnt       <= CW'(WAIT_CYCLES);
                  req_ready <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  rsp_rdata <= (we_q || err_c) ? 32'h0 : mem[idx_c];
                  rsp_err   <= err_c;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of transactions plus multi-cycle corner sequences.
// Expectations follow the DMEM_ADDR_CHECK_EN setting of the build.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned WC    = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_we    (req_we),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request, wait for its response, count edges from acceptance to rsp_valid.
   task automatic xact(input logic [31:0] a, input logic we, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er,
                       output int lat);
      int n;
      req_addr  = a;
      req_we    = we;
      req_wdata = d;
      req_wstrb = s;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = 32'hx;
      lat = 1;
      while (!rsp_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      lat = lat - 1;
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] held;
      logic        er;
      int          lat;
      int          acc[$];
      int          rsp_e[$];
      bit          saw_valid;

      vecs.push_back('{"st10",    32'h10,  1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{"ld10",    32'h10,  1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{"st20",    32'h20,  1'b1, 32'h11223344, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{"st20p",   32'h20,  1'b1, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
      vecs.push_back('{"ld20",    32'h20,  1'b0, 32'h0,        4'hF, 32'h11BB33DD, 1'b0});
      vecs.push_back('{"st20z",   32'h20,  1'b1, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
      vecs.push_back('{"ld20b",   32'h20,  1'b0, 32'h0,        4'h0, 32'h11BB33DD, 1'b0});
      vecs.push_back('{"st40",    32'h40,  1'b1, 32'h01020304, 4'hF, 32'h0,        1'b0});
`ifdef DMEM_ADDR_CHECK_EN
      vecs.push_back('{"st13err", 32'h13,  1'b1, 32'h55555555, 4'hF, 32'h0,        1'b1});
      vecs.push_back('{"ld10chk", 32'h10,  1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{"ldoob",   32'h100, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1});
`else
      vecs.push_back('{"st_alias",32'h100, 1'b1, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{"ld0",     32'h0,   1'b0, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0});
      vecs.push_back('{"ld13",    32'h13,  1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
`endif

      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_we    = 1'b0;
      req_wdata = '0;
      req_wstrb = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err",   32'(rsp_err), 32'd0);

      foreach (vecs[i]) begin
         xact(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].wstrb, rd, er, lat);
         chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         chk({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'(WC + 1));
      end

      // Backpressure: response held for 5 cycles with rsp_ready low.
      req_addr  = 32'h20;
      req_we    = 1'b0;
      req_wstrb = 4'h0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (WC + 1) @(posedge clk);
      #1;
      held = rsp_rdata;
      chk("bp_first", held, 32'h11BB33DD);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rdata", rsp_rdata, 32'h11BB33DD);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
      chk("bp_rel_ready", 32'(req_ready), 32'd1);

      // Reset while a store waits: store dropped, no response.
      req_addr  = 32'h40;
      req_we    = 1'b1;
      req_wdata = 32'hCAFEF00D;
      req_wstrb = 4'hF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      saw_valid = 1'b0;
      repeat (WC + 3) begin
         @(posedge clk); #1;
         if (rsp_valid) saw_valid = 1'b1;
      end
      chk("post_rst_no_rsp", 32'(saw_valid), 32'd0);
      xact(32'h40, 1'b0, 32'h0, 4'h0, rd, er, lat);
      chk("post_rst_ld40", rd, 32'h01020304);

      // Back-to-back loads with rsp_ready tied high.
      req_addr  = 32'h10;
      req_we    = 1'b0;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      for (int e = 0; e < 4 * (WC + 3) + 2; e++) begin
         if (req_ready) acc.push_back(e + 1);
         @(posedge clk); #1;
         if (rsp_valid) begin
            rsp_e.push_back(e + 1);
            chk("b2b_rdata", rsp_rdata, 32'hDEADBEEF);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("b2b_n_acc", 32'(acc.size() >= 3), 32'd1);
      chk("b2b_n_rsp", 32'(rsp_e.size() >= 3), 32'd1);
      if (acc.size() >= 3 && rsp_e.size() >= 3) begin
         for (int k = 0; k < 3; k++) begin
            chk("b2b_rsp_edge", 32'(rsp_e[k] - acc[k]), 32'(WC + 1));
         end
         for (int k = 1; k < 3; k++) begin
            chk("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'(WC + 3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
